// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, legal-opcode check and the result-register state type.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b1000;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Opcodes arrive zero-extended so any OPCODE_LENGTH >= 4 decodes identically.
  function automatic logic is_legal_op(input logic [31:0] op);
    return (op == 32'(OP_AND)) || (op == 32'(OP_OR))  || (op == 32'(OP_ADD)) ||
           (op == 32'(OP_XOR)) || (op == 32'(OP_SUB)) || (op == 32'(OP_EQ));
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/XOR/SUB/EQ; unsupported opcodes yield zero.
// Zero latency, no flow control.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic [OPCODE_LENGTH-1:0] op,
  output logic [DATA_WIDTH-1:0]    result
);

  always_comb begin
    result = '0;
    case (32'(op))
      32'(OP_AND): result = src_a & src_b;
      32'(OP_OR):  result = src_a | src_b;
      32'(OP_ADD): result = src_a + src_b;
      32'(OP_XOR): result = src_a ^ src_b;
      32'(OP_SUB): result = src_a - src_b;
      32'(OP_EQ):  result = {{(DATA_WIDTH-1){1'b0}}, (src_a == src_b)};
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past last_grant, first asserted request wins.
// Purely combinational; one-hot grant, all-zero when nothing requests.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters round-robin; result registered 1 cycle after accept,
// accepts only when the result register is empty or draining. Define ALU_ARBITER_ILLEGAL_OP_EN for rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic                             rsp_err
);

  localparam int IDW = $clog2(NUM_REQ);

  rsp_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [IDW-1:0]         last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0]       grant;
  logic                     can_accept;
  logic                     xfer;
  logic [IDW-1:0]           gnt_idx;
  logic [DATA_WIDTH-1:0]    a_sel, b_sel, alu_y;
  logic [OPCODE_LENGTH-1:0] op_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign can_accept = (state_q == RSP_EMPTY) || rsp_ready;
  // Qualified with rst_n so no requester sees an accept while reset is held.
  assign req_ready  = grant & {NUM_REQ{can_accept & rst_n}};
  assign xfer       = |(req_ready & req_valid);

  always_comb begin
    gnt_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    op_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = IDW'(i);
        a_sel   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        op_sel  = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
      end
    end
  end

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .src_a  (a_sel),
    .src_b  (b_sel),
    .op     (op_sel),
    .result (alu_y)
  );

  // A new accept wins over a drain so back-to-back results never leave a bubble.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      state_d      = RSP_FULL;
      data_d       = alu_y;
      id_d         = gnt_idx;
      last_grant_d = gnt_idx;
    end else if (rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RSP_EMPTY;
      data_q       <= '0;
      id_q         <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef ALU_ARBITER_ILLEGAL_OP_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (xfer) err_d = !is_legal_op(32'(op_sel));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = (state_q == RSP_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept strobe.
REQ-008 req_a  input  NUM_REQ*DATA_WIDTH  packed SrcA operands, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_b  input  NUM_REQ*DATA_WIDTH  packed SrcB operands, same packing.
REQ-010 req_op  input  NUM_REQ*OPCODE_LENGTH  packed ALU opcodes, requester i at [i*OPCODE_LENGTH +: OPCODE_LENGTH].
REQ-011 rsp_valid  output  1  result register holds an undelivered result.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_data  output  DATA_WIDTH  registered ALU result.
REQ-014 rsp_id  output  $clog2(NUM_REQ)  index of requester owning rsp_data.
REQ-015 rsp_err  output  1  illegal-opcode flag for current result.

Function
REQ-016 The block SHALL instantiate exactly one ALU and share it among all requesters.
REQ-017 Output state machine SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-018 can_accept SHALL equal (state==EMPTY) or rsp_ready.
REQ-019 Grant SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, first asserted req_valid wins.
REQ-020 req_ready[i] SHALL be 1 only for the granted requester and only when can_accept; at most one bit set per cycle.
REQ-021 Transfer occurs when req_valid[i] and req_ready[i]; last_grant SHALL update to i only on transfer.
REQ-022 On transfer in cycle N, rsp_data/rsp_id/rsp_err SHALL be registered and rsp_valid=1 from cycle N+1 (latency 1).
REQ-023 Simultaneous rsp_ready drain and new transfer SHALL reload the register with no bubble (1 op/cycle sustained).
REQ-024 rsp_ready with no new transfer in FULL SHALL move to EMPTY; rsp_data holds last value.
REQ-025 In FULL without rsp_ready, rsp_data, rsp_id, rsp_err SHALL remain stable and all req_ready SHALL be 0.
REQ-026 Requesters SHALL hold req_valid and operands stable until accepted; a deasserted req_valid forfeits nothing and does not move last_grant.
REQ-027 Result width SHALL be DATA_WIDTH; ADD/SUB wrap modulo 2^DATA_WIDTH; compare results zero-extended to DATA_WIDTH.
REQ-028 Unsupported opcodes SHALL produce rsp_data=0.

Reset
REQ-029 rst_n low SHALL immediately force state=EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req_ready=0, last_grant=NUM_REQ-1.
REQ-030 Reset mid-operation SHALL discard any pending result; first grant after release goes to lowest-index valid requester.

Configuration
REQ-031 Macro ALU_ARBITER_ILLEGAL_OP_EN defined: rsp_err SHALL be 1 for any opcode outside {0000,0001,0010,0100,0110,1000}, registered with the result.
REQ-032 Macro undefined: rsp_err SHALL be tied to 0 and no decode logic synthesised.

Structure
REQ-033 Opcode constants (AND, OR, ADD, XOR, SUB, EQ) and the legal-opcode function SHALL live in shared package alu_pkg.
REQ-034 The round-robin grant logic SHALL be sub-module rr_arbiter (inputs req, last_grant; output one-hot grant).
REQ-035 The existing alu module SHALL be instantiated unmodified as the datapath.

Verification
REQ-036 Single op: req0 valid, a=5, b=3, op=0010, rsp_ready=1 -> req_ready[0]=1 same cycle; next cycle rsp_valid=1, rsp_data=8, rsp_id=0.
REQ-037 Fairness: all 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-038 Backpressure: FULL with rsp_ready=0 for 5 cycles, req1 valid -> req_ready=0 throughout, rsp_data stable; rsp_ready=1 -> req1 accepted that cycle.
REQ-039 Wrap/compare: a=32'hFFFFFFFF, b=1, op=0010 -> rsp_data=0; a=b=7, op=1000 -> rsp_data=1; a=0, b=1, op=0110 -> 32'hFFFFFFFF.
REQ-040 Illegal op: op=0011 -> rsp_data=0; rsp_err=1 with ALU_ARBITER_ILLEGAL_OP_EN, 0 without.
REQ-041 Reset mid-op: rst_n low while FULL -> rsp_valid=0 asynchronously; after release with req2 and req3 valid, req2 granted first.
